// File: rtl/ysyx_22041412_mdu_pkg.sv
// Shared MDU definitions: funct3 codes, multiplier sign-mode encodings, control FSM states.
package ysyx_22041412_mdu_pkg;

  localparam logic [2:0] MUL_F3_MUL    = 3'b000;
  localparam logic [2:0] MUL_F3_MULH   = 3'b001;
  localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
  localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

  // mul_signed bit 1 qualifies the multiplicand, bit 0 the multiplier
  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic       w;
    logic [1:0] sgn;
    logic       hi;
  } mul_ctrl_t;

endpackage

// File: rtl/ysyx_22041412_mul_decode.sv
// Combinational funct3/word decode into multiplier controls {w, signed, hi}; zero latency, no flow control.
module ysyx_22041412_mul_decode
  import ysyx_22041412_mdu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       word_i,
  output mul_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.w   = word_i;
    ctrl_o.sgn = SGN_SS;
    ctrl_o.hi  = 1'b0;
    if (!word_i) begin
      case (funct3_i)
        MUL_F3_MULH: ctrl_o.hi = 1'b1;
        MUL_F3_MULHSU: begin
          ctrl_o.sgn = SGN_SU;
          ctrl_o.hi  = 1'b1;
        end
        MUL_F3_MULHU: begin
          ctrl_o.sgn = SGN_UU;
          ctrl_o.hi  = 1'b1;
        end
        default: ctrl_o.hi = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041412_mul_ctrl.sv
// Multiplier front-end: one op in flight, latency set by the multiplier, result held until wb_ready_i.
// YSYX_22041412_MUL_ZERO_BYPASS_EN: zero operand skips the multiplier and answers 0 the next cycle.
module ysyx_22041412_mul_ctrl
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [2:0]      ex_funct3_i,
  input  logic            ex_word_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [RD_W-1:0] ex_rd_i,
  input  logic            flush_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic            busy_o,
  output logic            mul_req_o,
  output logic [XLEN-1:0] mul_a_o,
  output logic [XLEN-1:0] mul_b_o,
  output logic            mul_w_o,
  output logic [1:0]      mul_signed_o,
  output logic            mul_hi_o,
  output logic            mul_flush_o,
  output logic            mul_ready_o,
  input  logic            mul_valid_i,
  input  logic [XLEN-1:0] mul_result_i
);

  mdu_state_e      state_q, state_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  logic [RD_W-1:0] rd_q, rd_d;
  mul_ctrl_t       ctrl_q, ctrl_d, dec_ctrl;
  logic            drain_q, drain_d;

  ysyx_22041412_mul_decode u_decode (
    .funct3_i (ex_funct3_i),
    .word_i   (ex_word_i),
    .ctrl_o   (dec_ctrl)
  );

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    drain_d  = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && !flush_i) begin
          rs1_d  = ex_rs1_i;
          rs2_d  = ex_rs2_i;
          rd_d   = ex_rd_i;
          ctrl_d = dec_ctrl;
`ifdef YSYX_22041412_MUL_ZERO_BYPASS_EN
          if (ex_rs1_i == '0 || ex_rs2_i == '0) begin
            state_d  = ST_RESP;
            result_d = '0;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        // Flush beats a coincident result pulse; the multiplier is drained instead.
        if (flush_i) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else if (mul_valid_i) begin
          state_d  = ST_RESP;
          result_d = ctrl_q.w ? {{(XLEN-32){mul_result_i[31]}}, mul_result_i[31:0]}
                              : mul_result_i;
        end
      end
      ST_RESP: begin
        if (flush_i) begin
          state_d  = ST_IDLE;
          result_d = '0;
        end else if (wb_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (flush_i) begin
          drain_d = 1'b0;
        end else if (drain_q) begin
          state_d = ST_IDLE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      drain_q  <= drain_d;
    end
  end

  // Request drops the cycle the result pulse arrives so the multiplier cannot restart.
  assign mul_req_o    = (state_q == ST_REQ) && !mul_valid_i && !flush_i;
  assign mul_flush_o  = (state_q != ST_IDLE) && flush_i;
  assign ex_ready_o   = (state_q == ST_IDLE) && !flush_i;
  assign busy_o       = (state_q != ST_IDLE);
  assign wb_valid_o   = (state_q == ST_RESP) && !flush_i;
  assign wb_data_o    = result_q;
  assign wb_rd_o      = rd_q;
  assign mul_a_o      = rs1_q;
  assign mul_b_o      = rs2_q;
  assign mul_w_o      = ctrl_q.w;
  assign mul_signed_o = ctrl_q.sgn;
  assign mul_hi_o     = ctrl_q.hi;
  assign mul_ready_o  = 1'b1;

endmodule

// File: tb/tb_ysyx_22041412_mul_ctrl.sv
// Bench for ysyx_22041412_mul_ctrl: behavioural multiplier, vector table, scoreboard on the WB port.
module tb_ysyx_22041412_mul_ctrl;
  import ysyx_22041412_mdu_pkg::*;

  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid_i, ex_ready_o, ex_word_i, flush_i;
  logic [2:0]      ex_funct3_i;
  logic [XLEN-1:0] ex_rs1_i, ex_rs2_i;
  logic [RD_W-1:0] ex_rd_i;
  logic            wb_valid_o, wb_ready_i, busy_o;
  logic [XLEN-1:0] wb_data_o;
  logic [RD_W-1:0] wb_rd_o;
  logic            mul_req_o, mul_w_o, mul_hi_o, mul_flush_o, mul_ready_o;
  logic [XLEN-1:0] mul_a_o, mul_b_o;
  logic [1:0]      mul_signed_o;
  logic            mul_valid_i;
  logic [XLEN-1:0] mul_result_i;

  always #5 clk = ~clk;

  ysyx_22041412_mul_ctrl #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_funct3_i(ex_funct3_i),
    .ex_word_i(ex_word_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
    .flush_i(flush_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .busy_o(busy_o),
    .mul_req_o(mul_req_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_w_o(mul_w_o),
    .mul_signed_o(mul_signed_o), .mul_hi_o(mul_hi_o), .mul_flush_o(mul_flush_o),
    .mul_ready_o(mul_ready_o), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];
  int   n_vec = 0, n_err = 0, hs_cnt = 0, req_cyc = 0, exp_hs = 0;
  int   mdl_lat = 3, mdl_cnt = 0;
  logic mdl_busy = 1'b0, ignore_flush = 1'b0;
  logic [63:0] mdl_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sg, input logic hi);
    logic [127:0] ea, eb, p;
    ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return hi ? p[127:64] : p[63:0];
  endfunction

  // Behavioural iterative multiplier: fixed latency per op, one-cycle result pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      mul_valid_i = 1'b0;
      mdl_busy    = 1'b0;
    end else if (mul_flush_o && !ignore_flush) begin
      mul_valid_i = 1'b0;
      mdl_busy    = 1'b0;
    end else if (mul_valid_i) begin
      mul_valid_i = 1'b0;
    end else if (mdl_busy) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        mul_valid_i  = 1'b1;
        mul_result_i = mdl_res;
        mdl_busy     = 1'b0;
      end
    end else if (mul_req_o) begin
      mdl_busy = 1'b1;
      mdl_cnt  = mdl_lat;
      mdl_res  = model_mul(mul_a_o, mul_b_o, mul_signed_o, mul_hi_o);
    end
  end

  // WB-side scoreboard and request-drop check.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (mul_req_o) req_cyc++;
      if (mul_valid_i) chk("req_drop", {63'd0, mul_req_o}, 64'd0);
      if (wb_valid_o && wb_ready_i) begin
        hs_cnt++;
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_wb: got data %h, no result outstanding", wb_data_o);
        end else begin
          e = sbq.pop_front();
          chk("wb_data", wb_data_o, e.d);
          chk("wb_rd", {59'd0, wb_rd_o}, {59'd0, e.rd});
        end
      end
    end
  end

  task automatic issue(input vec_t v, input logic push);
    int k;
    k = 0;
    while (!ex_ready_o && k < 100) begin
      tick();
      k++;
    end
    chk("issue_ready", {63'd0, ex_ready_o}, 64'd1);
    mdl_lat     = v.lat;
    ex_valid_i  = 1'b1;
    ex_funct3_i = v.f3;
    ex_word_i   = v.w;
    ex_rs1_i    = v.a;
    ex_rs2_i    = v.b;
    ex_rd_i     = v.rd;
    if (push) sbq.push_back('{d: v.exp, rd: v.rd});
    tick();
    // Scramble upstream after accept; the block must ignore it.
    ex_valid_i  = 1'b0;
    ex_funct3_i = 3'b011;
    ex_word_i   = ~v.w;
    ex_rs1_i    = ~v.a;
    ex_rs2_i    = ~v.b;
    ex_rd_i     = ~v.rd;
  endtask

  task automatic wait_hs(input int target, input string name);
    int k;
    k = 0;
    while (hs_cnt < target && k < 200) begin
      tick();
      k++;
    end
    chk(name, 64'(hs_cnt), 64'(target));
  endtask

  task automatic wait_wbv();
    int k;
    k = 0;
    while (!wb_valid_o && k < 100) begin
      tick();
      k++;
    end
    chk("wbv_seen", {63'd0, wb_valid_o}, 64'd1);
  endtask

  initial begin
    int r0;
    vec_t z;
    ex_valid_i = 1'b0; ex_funct3_i = '0; ex_word_i = 1'b0;
    ex_rs1_i = '0; ex_rs2_i = '0; ex_rd_i = '0;
    flush_i = 1'b0; wb_ready_i = 1'b1; mul_valid_i = 1'b0; mul_result_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wbv",   {63'd0, wb_valid_o},  64'd0);
    chk("rst_busy",  {63'd0, busy_o},      64'd0);
    chk("rst_req",   {63'd0, mul_req_o},   64'd0);
    chk("rst_ready", {63'd0, ex_ready_o},  64'd1);
    chk("rst_flush", {63'd0, mul_flush_o}, 64'd0);
    chk("rst_data",  wb_data_o,            64'd0);
    chk("rst_a",     mul_a_o,              64'd0);
    chk("rst_sgn",   {62'd0, mul_signed_o}, 64'd0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{MUL_F3_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 5};
    vecs[1] = '{MUL_F3_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'h1, 8};
    vecs[2] = '{MUL_F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[3] = '{MUL_F3_MUL,    1'b1, 64'h0000_0000_4000_0000, 64'd2, 5'd4, 64'hFFFF_FFFF_8000_0000, 36};
    vecs[4] = '{MUL_F3_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 5'd5, 64'h1, 12};
    vecs[5] = '{MUL_F3_MUL,    1'b0, 64'd6, 64'd7, 5'd6, 64'd42, 2};
    vecs[6] = '{MUL_F3_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h0, 20};
    vecs[7] = '{MUL_F3_MUL,    1'b1, 64'hFFFF_FFFF_0000_0003, 64'd5, 5'd8, 64'hF, 3};
    vecs[8] = '{MUL_F3_MULHU,  1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd31,
                64'h4000_0000_0000_0000, 17};

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i], 1'b1);
      exp_hs++;
      wait_hs(exp_hs, "table_hs");
    end

    // Writeback backpressure: result must hold for 10 cycles, single handshake.
    wb_ready_i = 1'b0;
    issue(vecs[1], 1'b1);
    exp_hs++;
    wait_wbv();
    for (int c = 0; c < 10; c++) begin
      chk("bp_wbv",   {63'd0, wb_valid_o}, 64'd1);
      chk("bp_data",  wb_data_o, 64'h1);
      chk("bp_ready", {63'd0, ex_ready_o}, 64'd0);
      tick();
    end
    wb_ready_i = 1'b1;
    wait_hs(exp_hs, "bp_hs");
    chk("bp_after_wbv", {63'd0, wb_valid_o}, 64'd0);
    tick();
    chk("bp_one_hs", 64'(hs_cnt), 64'(exp_hs));

    // Flush five cycles into REQ, then two drain cycles.
    issue('{MUL_F3_MUL, 1'b0, 64'd9, 64'd9, 5'd9, 64'd81, 20}, 1'b0);
    repeat (4) tick();
    flush_i = 1'b1;
    #1;
    chk("fl_pulse", {63'd0, mul_flush_o}, 64'd1);
    chk("fl_req",   {63'd0, mul_req_o},   64'd0);
    chk("fl_wbv",   {63'd0, wb_valid_o},  64'd0);
    tick();
    flush_i = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("dr_busy",  {63'd0, busy_o},      64'd1);
      chk("dr_ready", {63'd0, ex_ready_o},  64'd0);
      chk("dr_req",   {63'd0, mul_req_o},   64'd0);
      chk("dr_flush", {63'd0, mul_flush_o}, 64'd0);
      tick();
    end
    chk("dr_idle", {63'd0, ex_ready_o}, 64'd1);
    issue(vecs[5], 1'b1);
    exp_hs++;
    wait_hs(exp_hs, "post_flush_hs");

    // Multiplier already finishing when flushed: its pulse lands in DRAIN and must vanish.
    ignore_flush = 1'b1;
    issue('{MUL_F3_MUL, 1'b0, 64'd3, 64'd3, 5'd10, 64'd9, 2}, 1'b0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stray_wbv", {63'd0, wb_valid_o}, 64'd0);
      tick();
    end
    ignore_flush = 1'b0;
    issue('{MUL_F3_MUL, 1'b0, 64'd11, 64'd12, 5'd11, 64'd132, 4}, 1'b1);
    exp_hs++;
    wait_hs(exp_hs, "post_stray_hs");

    // Flush while holding a result.
    wb_ready_i = 1'b0;
    issue('{MUL_F3_MUL, 1'b0, 64'd5, 64'd5, 5'd12, 64'd25, 3}, 1'b0);
    wait_wbv();
    flush_i = 1'b1;
    #1;
    chk("rf_wbv",   {63'd0, wb_valid_o},  64'd0);
    chk("rf_flush", {63'd0, mul_flush_o}, 64'd1);
    tick();
    flush_i = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    chk("rf_idle", {63'd0, busy_o}, 64'd0);

    // Flush in IDLE blocks a simultaneous offer.
    flush_i = 1'b1;
    ex_valid_i = 1'b1;
    ex_rs1_i = 64'd2;
    ex_rs2_i = 64'd2;
    #1;
    chk("if_ready", {63'd0, ex_ready_o}, 64'd0);
    tick();
    flush_i = 1'b0;
    ex_valid_i = 1'b0;
    chk("if_busy", {63'd0, busy_o}, 64'd0);

    // Zero operand.
    r0 = req_cyc;
    z = '{MUL_F3_MUL, 1'b0, 64'd0, 64'h1234, 5'd13, 64'd0, 6};
    issue(z, 1'b1);
    exp_hs++;
`ifdef YSYX_22041412_MUL_ZERO_BYPASS_EN
    chk("byp_wbv", {63'd0, wb_valid_o}, 64'd1);
`else
    chk("byp_wbv", {63'd0, wb_valid_o}, 64'd0);
`endif
    wait_hs(exp_hs, "zero_hs");
`ifdef YSYX_22041412_MUL_ZERO_BYPASS_EN
    chk("byp_noreq", 64'(req_cyc - r0), 64'd0);
`else
    chk("byp_req", {63'd0, (req_cyc > r0)}, 64'd1);
`endif

    repeat (3) tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
